// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage pipelined IEEE-754 multiplier (binary32/binary64)
//
// Optional build macro: FP_MUL_STICKY_FLAGS_EN enables the sticky flag register.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready drops only while the output is stalled
//   A, B, in_tag        operands and sideband tag
//   out_valid/out_ready result handshake
//   Result, out_tag     product and the tag that entered with it
//   flags               {invalid, overflow, underflow, inexact} for Result
//   clr_flags           clears flags_sticky (sticky build only)
//   flags_sticky        OR of flags over all delivered results (0 when sticky build is off)
module fp_mul_pipe #(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     Result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags,
    input  logic             clr_flags,
    output logic [3:0]       flags_sticky
);

    localparam int M  = (N == 64) ? 52 : 23;
    localparam int E  = (N == 64) ? 11 : 8;
    localparam int P  = 2 * M + 2;
    localparam int XW = E + 2;
    localparam logic signed [XW-1:0] BIAS    = XW'((1 << (E - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << E) - 1);
    localparam logic [N-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    // Special-case class decided in S1 and carried down the pipe
    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_QNAN,
        CLS_INVALID,
        CLS_INF,
        CLS_ZERO
    } cls_t;

    logic stall;
    logic advance;

    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;

    // ---------------- S1: unpack / classify ----------------
    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb;
    logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    cls_t         cls_in;

    assign ea = A[N-2:M];
    assign eb = B[N-2:M];
    assign fa = A[M-1:0];
    assign fb = B[M-1:0];

    // exp==0 covers both true zeros and subnormals, which are flushed to zero
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);

    always_comb begin
        cls_in = CLS_NORM;
        if (a_nan || b_nan)
            cls_in = CLS_QNAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            cls_in = CLS_INVALID;
        else if (a_inf || b_inf)
            cls_in = CLS_INF;
        else if (a_zero || b_zero)
            cls_in = CLS_ZERO;
    end

    logic             s1_valid, s1_sign;
    cls_t             s1_cls;
    logic [E-1:0]     s1_ea, s1_eb;
    logic [M:0]       s1_ma, s1_mb;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= CLS_NORM;
            s1_ea    <= '0;
            s1_eb    <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_tag   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= A[N-1] ^ B[N-1];
            s1_cls   <= cls_in;
            s1_ea    <= ea;
            s1_eb    <= eb;
            s1_ma    <= {1'b1, fa};
            s1_mb    <= {1'b1, fb};
            s1_tag   <= in_tag;
        end
    end

    // ---------------- S2: significand multiply ----------------
    logic                  s2_valid, s2_sign;
    cls_t                  s2_cls;
    logic [P-1:0]          s2_prod;
    logic signed [XW-1:0]  s2_exp;
    logic [TAG_W-1:0]      s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_cls   <= CLS_NORM;
            s2_prod  <= '0;
            s2_exp   <= '0;
            s2_tag   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_cls   <= s1_cls;
            s2_prod  <= s1_ma * s1_mb;
            s2_exp   <= {2'b00, s1_ea} + {2'b00, s1_eb} - BIAS;
            s2_tag   <= s1_tag;
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic                 norm, guard, sticky, round_up, carry;
    logic [P-1:0]         shifted;
    logic [M-1:0]         mant;
    logic [M:0]           mant_r;
    logic signed [XW-1:0] exp_f;
    logic                 ovf, unf;
    logic [N-1:0]         res_n;
    logic [3:0]           fl_n;
    logic                 unused_hidden;

    // Product lies in [1,4); align so the hidden bit always sits at P-1
    assign norm          = s2_prod[P-1];
    assign shifted       = norm ? s2_prod : {s2_prod[P-2:0], 1'b0};
    assign unused_hidden = shifted[P-1];
    assign mant          = shifted[P-2:M+1];
    assign guard         = shifted[M];
    assign sticky        = |shifted[M-1:0];
    assign round_up      = guard & (sticky | mant[0]);
    assign mant_r        = {1'b0, mant} + (M+1)'(round_up);
    // Carry-out only happens from an all-ones fraction, so the fraction wraps to zero
    assign carry         = mant_r[M];
    assign exp_f         = s2_exp + XW'(norm) + XW'(carry);
    assign ovf           = (exp_f >= EXP_MAX);
    assign unf           = exp_f[XW-1] || (exp_f == '0);

    always_comb begin
        res_n = {s2_sign, exp_f[E-1:0], mant_r[M-1:0]};
        fl_n  = {3'b000, guard | sticky};
        case (s2_cls)
            CLS_QNAN: begin
                res_n = QNAN;
                fl_n  = 4'b0000;
            end
            CLS_INVALID: begin
                res_n = QNAN;
                fl_n  = 4'b1000;
            end
            CLS_INF: begin
                res_n = {s2_sign, {E{1'b1}}, {M{1'b0}}};
                fl_n  = 4'b0000;
            end
            CLS_ZERO: begin
                res_n = {s2_sign, {(N-1){1'b0}}};
                fl_n  = 4'b0000;
            end
            default: begin
                if (ovf) begin
                    res_n = {s2_sign, {E{1'b1}}, {M{1'b0}}};
                    fl_n  = 4'b0101;
                end else if (unf) begin
                    res_n = {s2_sign, {(N-1){1'b0}}};
                    fl_n  = 4'b0011;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Result    <= '0;
            out_tag   <= '0;
            flags     <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            // Bubbles leave the last delivered result on the bus
            if (s2_valid) begin
                Result  <= res_n;
                out_tag <= s2_tag;
                flags   <= fl_n;
            end
        end
    end

    // ---------------- sticky flags ----------------
`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [3:0] hs_flags;

    assign hs_flags = (out_valid & out_ready) ? flags : 4'b0000;

    // A handshake in the clearing cycle survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags_sticky <= 4'b0000;
        else if (clr_flags)
            flags_sticky <= hs_flags;
        else
            flags_sticky <= flags_sticky | hs_flags;
    end
`else
    logic unused_clr;

    assign unused_clr   = clr_flags;
    assign flags_sticky = 4'b0000;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed vector bench for fp_mul_pipe (N=32)
module tb_fp_mul_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    localparam int NV = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  out_tag;
    logic [3:0]  flags;
    logic        clr_flags;
    logic [3:0]  flags_sticky;

    vec_t vec [NV];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [3:0] acc_fl;
    logic [3:0] sticky_exp;

    fp_mul_pipe #(.N(32), .TAG_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .A            (a),
        .B            (b),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .Result       (result),
        .out_tag      (out_tag),
        .flags        (flags),
        .clr_flags    (clr_flags),
        .flags_sticky (flags_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_one(input int i);
        int lat;
        @(negedge clk);
        a        = vec[i].a;
        b        = vec[i].b;
        in_tag   = vec[i].tag;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency%0d", i), 64'(lat), 64'd3);
        check($sformatf("result%0d", i), {32'd0, result}, {32'd0, vec[i].res});
        check($sformatf("tag%0d", i), {60'd0, out_tag}, {60'd0, vec[i].tag});
        check($sformatf("flags%0d", i), {60'd0, flags}, {60'd0, vec[i].fl});
    endtask

    initial begin
        int sent, got, cyc, stall_n, seen;
        logic first;

        vec[0]  = '{32'h40000000, 32'h40400000, 4'h3, 32'h40C00000, 4'b0000};
        vec[1]  = '{32'h3F800001, 32'h3F800001, 4'h1, 32'h3F800002, 4'b0001};
        vec[2]  = '{32'h7F000000, 32'h40000000, 4'h2, 32'h7F800000, 4'b0101};
        vec[3]  = '{32'h7F800000, 32'h00000000, 4'h4, 32'h7FC00000, 4'b1000};
        vec[4]  = '{32'h7F800001, 32'h3F800000, 4'h5, 32'h7FC00000, 4'b0000};
        vec[5]  = '{32'hC0000000, 32'h40400000, 4'h6, 32'hC0C00000, 4'b0000};
        vec[6]  = '{32'h7F800000, 32'hC0000000, 4'h7, 32'hFF800000, 4'b0000};
        vec[7]  = '{32'h80000000, 32'h40A00000, 4'h8, 32'h80000000, 4'b0000};
        vec[8]  = '{32'h00000001, 32'hC0000000, 4'h9, 32'h80000000, 4'b0000};
        vec[9]  = '{32'h00800000, 32'h00800000, 4'hA, 32'h00000000, 4'b0011};
        vec[10] = '{32'h3FC00000, 32'h3FC00000, 4'hB, 32'h40100000, 4'b0000};
        vec[11] = '{32'h3F800001, 32'h3FC00000, 4'hC, 32'h3FC00002, 4'b0001};
        vec[12] = '{32'h3F800003, 32'h3FC00000, 4'hD, 32'h3FC00004, 4'b0001};
        vec[13] = '{32'h3FFFFFFE, 32'h3F800001, 4'hE, 32'h40000000, 4'b0001};
        vec[14] = '{32'h7F7FFFFF, 32'h3F800000, 4'hF, 32'h7F7FFFFF, 4'b0000};
        vec[15] = '{32'h80800000, 32'h3F000000, 4'h0, 32'h80000000, 4'b0011};
        vec[16] = '{32'h00800000, 32'h3F800000, 4'h1, 32'h00800000, 4'b0000};
        vec[17] = '{32'hFF800000, 32'hFF800000, 4'h2, 32'h7F800000, 4'b0000};
        vec[18] = '{32'h7FC00000, 32'h7F800000, 4'h3, 32'h7FC00000, 4'b0000};
        vec[19] = '{32'hFFFFFFFF, 32'h00000000, 4'h4, 32'h7FC00000, 4'b0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        clr_flags = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_flags", {60'd0, flags}, 64'd0);
        check("rst_sticky", {60'd0, flags_sticky}, 64'd0);
        rst_n = 1'b1;

        // Single operations, one at a time
        acc_fl = 4'b0000;
        for (int i = 0; i < NV; i++) begin
            run_one(i);
            acc_fl = acc_fl | vec[i].fl;
        end
        repeat (2) @(negedge clk);
`ifdef FP_MUL_STICKY_FLAGS_EN
        sticky_exp = acc_fl;
`else
        sticky_exp = 4'b0000;
`endif
        check("sticky_accum", {60'd0, flags_sticky}, {60'd0, sticky_exp});

        // Plain clear
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("sticky_clr", {60'd0, flags_sticky}, 64'd0);

        // Clear in the same cycle as a handshake keeps that result's flags
        @(negedge clk);
        a = vec[2].a; b = vec[2].b; in_tag = vec[2].tag; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("clr_hs_valid", {63'd0, out_valid}, 64'd1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
`ifdef FP_MUL_STICKY_FLAGS_EN
        sticky_exp = vec[2].fl;
`else
        sticky_exp = 4'b0000;
`endif
        check("clr_hs_sticky", {60'd0, flags_sticky}, {60'd0, sticky_exp});

        // Back-to-back stream with a 4-cycle output stall
        sent = 0; got = 0; cyc = 0; stall_n = 0; first = 1'b0;
        while (got < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !first) begin
                first   = 1'b1;
                stall_n = 4;
            end
            out_ready = (stall_n == 0);
            if (sent < 5) begin
                a = vec[sent + 5].a; b = vec[sent + 5].b; in_tag = vec[sent + 5].tag;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_n > 0) begin
                check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_result", {32'd0, result}, {32'd0, vec[5].res});
                stall_n--;
            end
            if (in_valid && in_ready)
                sent++;
            if (out_valid && out_ready) begin
                check($sformatf("stream_res%0d", got), {32'd0, result}, {32'd0, vec[got + 5].res});
                check($sformatf("stream_tag%0d", got), {60'd0, out_tag}, {60'd0, vec[got + 5].tag});
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(got), 64'd5);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("stream_no_dup", 64'(seen), 64'd0);

        // Reset with two operations in flight
        @(negedge clk);
        a = vec[0].a; b = vec[0].b; in_tag = vec[0].tag; in_valid = 1'b1;
        @(negedge clk);
        a = vec[1].a; b = vec[1].b; in_tag = vec[1].tag;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_result", {32'd0, result}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_sticky", {60'd0, flags_sticky}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_rst_stale", 64'(seen), 64'd0);
        run_one(13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
